// File: rtl/hand_pkg.sv
// Shared types and card-code constants for the baccarat hand scorer.
package hand_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } state_e;

  localparam int CARD_ACE  = 1;
  localparam int CARD_KING = 13;
  // Highest legal card code; anything above (or zero) is rejected.
  localparam int CARD_MAX_VALID = CARD_KING;

endpackage

// File: rtl/card_value.sv
// Combinational card code -> score value map with a legality flag.
module card_value
  import hand_pkg::*;
#(
  parameter int CARD_W   = 4,
  parameter int FACE_MIN = 10,
  parameter int VAL_W    = 4
) (
  input  logic [CARD_W-1:0] code_i,
  output logic [VAL_W-1:0]  value_o,
  output logic              valid_o
);

  assign valid_o = (32'(code_i) >= CARD_ACE) && (32'(code_i) <= CARD_MAX_VALID);
  // Codes below FACE_MIN are below MOD, so the narrowing cast never drops bits.
  assign value_o = (32'(code_i) < FACE_MIN) ? VAL_W'(code_i) : '0;

endmodule

// File: rtl/hand_scorer.sv
// One baccarat hand: accepts a card per cycle, keeps the score mod MOD,
// counts cards and closes the hand on a natural or when full.
module hand_scorer
  import hand_pkg::*;
#(
  parameter int CARD_W      = 4,
  parameter int MAX_CARDS   = 3,
  parameter int MOD         = 10,
  parameter int FACE_MIN    = 10,
  parameter int NATURAL_EN  = 1,
  parameter int NATURAL_MIN = 8,
  localparam int TOT_W      = $clog2(MOD),
  localparam int CNT_W      = $clog2(MAX_CARDS + 1)
) (
  input  logic              slow_clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              card_valid,
  input  logic [CARD_W-1:0] card_in,
  output logic              card_ready,
  output logic [TOT_W-1:0]  total,
  output logic [CNT_W-1:0]  num_cards,
  output logic              hand_full,
  output logic              natural,
  output logic              bad_card
);

  state_e             state_q;
  logic [TOT_W-1:0]   total_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               natural_q;
  logic               bad_q;

  logic [TOT_W-1:0]   val;
  logic               card_ok;
  logic               take;
  logic [TOT_W:0]     sum_raw;
  logic [TOT_W:0]     sum_red;
  logic [TOT_W-1:0]   total_d;
  logic               is_nat;
  logic               last_card;

  card_value #(
    .CARD_W  (CARD_W),
    .FACE_MIN(FACE_MIN),
    .VAL_W   (TOT_W)
  ) u_card_value (
    .code_i (card_in),
    .value_o(val),
    .valid_o(card_ok)
  );

  assign take    = card_valid & card_ready & ~clear;
  // value < MOD, so a single conditional subtract keeps the sum in range.
  assign sum_raw = {1'b0, total_q} + {1'b0, val};
  assign sum_red = (sum_raw >= (TOT_W+1)'(MOD)) ? sum_raw - (TOT_W+1)'(MOD) : sum_raw;
  assign total_d = sum_red[TOT_W-1:0];

  assign is_nat    = (NATURAL_EN != 0) && (cnt_q == CNT_W'(1)) &&
                     (32'(total_d) >= NATURAL_MIN);
  assign last_card = (cnt_q == CNT_W'(MAX_CARDS - 1));

  always_ff @(posedge slow_clock) begin
    if (reset || clear) begin
      state_q   <= EMPTY;
      total_q   <= '0;
      cnt_q     <= '0;
      natural_q <= 1'b0;
      bad_q     <= 1'b0;
    end else begin
      bad_q <= 1'b0;
      if (take) begin
        if (!card_ok) begin
          bad_q <= 1'b1;
        end else begin
          total_q   <= total_d;
          cnt_q     <= cnt_q + CNT_W'(1);
          natural_q <= natural_q | is_nat;
          state_q   <= (last_card || is_nat) ? FULL : PARTIAL;
        end
      end
    end
  end

  assign card_ready = (state_q != FULL);
  assign hand_full  = (state_q == FULL);
  assign total      = total_q;
  assign num_cards  = cnt_q;
  assign natural    = natural_q;
  assign bad_card   = bad_q;

endmodule

// File: tb/tb_hand_scorer.sv
// Three hand_scorer configurations on shared stimulus, checked against a
// behavioural scoreboard plus a handful of fixed expectations.
module tb_hand_scorer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, clr, vld;
  logic [3:0] code;

  logic       rdy0, full0, nat0, bad0;
  logic [3:0] tot0;
  logic [1:0] nc0;
  logic       rdy1, full1, nat1, bad1;
  logic [3:0] tot1;
  logic [1:0] nc1;
  logic       rdy2, full2, nat2, bad2;
  logic [3:0] tot2;
  logic [2:0] nc2;

  hand_scorer u_dut0 (
    .slow_clock(clk), .reset(rst), .clear(clr), .card_valid(vld), .card_in(code),
    .card_ready(rdy0), .total(tot0), .num_cards(nc0), .hand_full(full0),
    .natural(nat0), .bad_card(bad0)
  );

  hand_scorer #(.NATURAL_EN(0)) u_dut1 (
    .slow_clock(clk), .reset(rst), .clear(clr), .card_valid(vld), .card_in(code),
    .card_ready(rdy1), .total(tot1), .num_cards(nc1), .hand_full(full1),
    .natural(nat1), .bad_card(bad1)
  );

  hand_scorer #(.MAX_CARDS(5), .MOD(16), .FACE_MIN(14), .NATURAL_EN(0)) u_dut2 (
    .slow_clock(clk), .reset(rst), .clear(clr), .card_valid(vld), .card_in(code),
    .card_ready(rdy2), .total(tot2), .num_cards(nc2), .hand_full(full2),
    .natural(nat2), .bad_card(bad2)
  );

  typedef struct packed {
    logic [4:0] tot;
    logic [2:0] cnt;
    logic       full;
    logic       nat;
    logic       bad;
    logic       rdy;
  } exp_t;

  exp_t sb_q[$];

  int c_max [3] = '{3, 3, 5};
  int c_mod [3] = '{10, 10, 16};
  int c_face[3] = '{10, 10, 14};
  int c_nen [3] = '{1, 0, 0};

  int m_tot[3], m_cnt[3];
  bit m_full[3], m_nat[3], m_bad[3];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t observe(input int d);
    exp_t o;
    case (d)
      0: begin o.tot = {1'b0, tot0}; o.cnt = {1'b0, nc0}; o.full = full0;
               o.nat = nat0; o.bad = bad0; o.rdy = rdy0; end
      1: begin o.tot = {1'b0, tot1}; o.cnt = {1'b0, nc1}; o.full = full1;
               o.nat = nat1; o.bad = bad1; o.rdy = rdy1; end
      default: begin o.tot = {1'b0, tot2}; o.cnt = nc2; o.full = full2;
               o.nat = nat2; o.bad = bad2; o.rdy = rdy2; end
    endcase
    return o;
  endfunction

  task automatic model(input int d, input bit r, input bit c, input bit v, input int cd);
    int val, s;
    if (r || c) begin
      m_tot[d] = 0; m_cnt[d] = 0; m_full[d] = 0; m_nat[d] = 0; m_bad[d] = 0;
    end else begin
      m_bad[d] = 0;
      if (v && !m_full[d]) begin
        if (cd < 1 || cd > 13) begin
          m_bad[d] = 1;
        end else begin
          val = (cd < c_face[d]) ? cd : 0;
          s = m_tot[d] + val;
          if (s >= c_mod[d]) s = s - c_mod[d];
          if (c_nen[d] != 0 && m_cnt[d] == 1 && s >= 8) begin
            m_nat[d] = 1; m_full[d] = 1;
          end
          m_tot[d] = s;
          m_cnt[d] = m_cnt[d] + 1;
          if (m_cnt[d] == c_max[d]) m_full[d] = 1;
        end
      end
    end
  endtask

  task automatic step(input bit r, input bit c, input bit v, input int cd);
    exp_t e, o;
    rst = r; clr = c; vld = v; code = 4'(cd);
    for (int d = 0; d < 3; d++) begin
      model(d, r, c, v, cd);
      e.tot = 5'(m_tot[d]); e.cnt = 3'(m_cnt[d]); e.full = m_full[d];
      e.nat = m_nat[d]; e.bad = m_bad[d]; e.rdy = !m_full[d];
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      e = sb_q.pop_front();
      o = observe(d);
      chk($sformatf("d%0d_total", d),     int'(o.tot),  int'(e.tot));
      chk($sformatf("d%0d_num_cards", d), int'(o.cnt),  int'(e.cnt));
      chk($sformatf("d%0d_hand_full", d), int'(o.full), int'(e.full));
      chk($sformatf("d%0d_natural", d),   int'(o.nat),  int'(e.nat));
      chk($sformatf("d%0d_bad_card", d),  int'(o.bad),  int'(e.bad));
      chk($sformatf("d%0d_card_ready", d), int'(o.rdy), int'(e.rdy));
    end
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; vld = 1'b0; code = '0;
    step(1, 0, 0, 0);
    chk("reset_ready", int'(rdy0), 1);
    chk("reset_total", int'(tot0), 0);

    // 7, K, 5 back to back, then an extra card a full hand must ignore
    step(0, 0, 1, 7);
    step(0, 0, 1, 13);
    step(0, 0, 1, 5);
    chk("tp1_total", int'(tot0), 2);
    chk("tp1_count", int'(nc0), 3);
    chk("tp1_ready", int'(rdy0), 0);
    step(0, 0, 1, 15);
    chk("full_no_bad", int'(bad0), 0);
    step(0, 0, 1, 3);

    // natural on 4,4; third card dropped by dut0
    step(0, 1, 0, 0);
    step(0, 0, 1, 4);
    step(0, 0, 1, 4);
    chk("tp2_nat", int'(nat0), 1);
    chk("tp2_full", int'(full0), 1);
    step(0, 0, 1, 5);
    chk("tp2_total", int'(tot0), 8);

    // wrap without natural
    step(0, 1, 0, 0);
    step(0, 0, 1, 9);
    step(0, 0, 1, 9);
    step(0, 0, 1, 9);
    chk("tp3_total", int'(tot1), 7);
    chk("tp3_full", int'(full1), 1);

    // illegal codes after a 3
    step(0, 1, 0, 0);
    step(0, 0, 1, 3);
    step(0, 0, 1, 14);
    chk("tp4_bad_a", int'(bad0), 1);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    chk("tp4_bad_b", int'(bad0), 1);
    step(0, 0, 0, 0);
    chk("tp4_total", int'(tot0), 3);

    // clear with a simultaneous card
    step(0, 0, 1, 2);
    step(0, 1, 1, 6);
    chk("tp5_total", int'(tot0), 0);
    step(0, 0, 0, 0);

    // wide-modulus config, then reset with a card in flight
    step(0, 0, 1, 13);
    step(0, 0, 1, 13);
    step(0, 0, 1, 13);
    chk("tp6_total", int'(tot2), 7);
    step(0, 0, 1, 13);
    step(0, 1, 0, 0);
    step(0, 0, 1, 13);
    step(1, 0, 1, 13);
    chk("tp6_rst_cnt", int'(nc2), 0);
    step(0, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 59) == 0, $urandom_range(0, 11) == 0,
           $urandom_range(0, 3) != 0, int'($urandom_range(0, 15)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hand_scorer.md
# hand_scorer

Sequential, parametrised card-hand scorer for the baccarat datapath. Accepts one card per cycle through a valid/ready handshake and keeps a running modulo score. Tracks the card count and detects a "natural" (two-card total at or above a threshold), which closes the hand early. It sits between the card dealer and the win/lose comparator, one instance per player/banker hand.

## Interface
- CARD_W, 4, width of card code (1=A, 2..10, 11=J, 12=Q, 13=K)
- MAX_CARDS, 3, cards per hand before the hand is full (2..7)
- MOD, 10, score modulus (2..16)
- FACE_MIN, 10, card codes >= FACE_MIN score 0; FACE_MIN <= MOD required
- NATURAL_EN, 1, enables natural detection
- NATURAL_MIN, 8, two-card total at or above which natural asserts
- slow_clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- clear  in  1  start new hand; synchronous, one-cycle pulse
- card_valid  in  1  card_in presented this cycle
- card_in  in  CARD_W  card code
- card_ready  out  1  hand can accept a card
- total  out  TOT_W=$clog2(MOD)  running score mod MOD
- num_cards  out  CNT_W=$clog2(MAX_CARDS+1)  accepted cards
- hand_full  out  1  no further cards accepted
- natural  out  1  natural detected this hand (sticky until clear/reset)
- bad_card  out  1  one-cycle pulse: invalid card rejected

## Operation
- States: EMPTY (0 cards), PARTIAL (1..MAX_CARDS-1), FULL.
- Accept = card_valid & card_ready & ~clear. card_ready = (state != FULL).
- Valid code: 1..13. Code 0 or >13 with card_valid & card_ready & ~clear -> bad_card=1 next cycle; total/num_cards unchanged.
- Value: code < FACE_MIN -> code, else 0. Sum = total + value (TOT_W+1 bits); if sum >= MOD subtract MOD once (value < MOD guarantees single subtract).
- On accept: total <= reduced sum; num_cards += 1; EMPTY->PARTIAL; ->FULL when num_cards reaches MAX_CARDS.
- Natural: if NATURAL_EN and the accepted card is the second and its reduced sum >= NATURAL_MIN, natural <= 1 and state -> FULL in the same edge.
- card_valid while FULL: ignored, no bad_card.
- clear: priority over card_valid; returns all outputs to reset values; a simultaneous card is discarded.
- reset: priority over everything.

## Timing
- Reset values: total=0, num_cards=0, hand_full=0, natural=0, bad_card=0, card_ready=1, state=EMPTY.
- All outputs registered; accept at edge N -> total/num_cards/hand_full/natural valid after edge N (1-cycle latency).
- Back-to-back accepts on consecutive cycles are supported; throughput 1 card/cycle.
- card_ready drops in the cycle after the accept that fills the hand; no card accepted beyond MAX_CARDS.
- bad_card high exactly one cycle after the offending edge.
- Reset or clear mid-hand: state back to EMPTY next edge; card_ready=1 the following cycle.

## Structure
- Package hand_pkg: state enum (EMPTY, PARTIAL, FULL), card code constants (CARD_ACE=1, CARD_KING=13), validity limit.
- Sub-module card_value: combinational code -> value map plus valid flag, parametrised by CARD_W, FACE_MIN.
- hand_scorer holds the FSM, the modulo accumulator and the counter.

## Test plan
- Reset then 7, K, 5 on three consecutive cycles -> total 7, 7, 2; num_cards 1, 2, 3; hand_full=1, card_ready=0; natural=0.
- 4, 4 -> total 8, natural=1, hand_full=1 after the 2nd card; a third card 5 is ignored, total stays 8.
- NATURAL_EN=0, 9, 9, 9 -> total 9, 8, 7 (wrap); hand_full after the 3rd card.
- Card 14 then card 0 after one card 3 -> bad_card pulses twice; total=3, num_cards=1.
- clear asserted with card_valid=1, card_in=6 mid-hand -> total=0, num_cards=0, natural=0, card_ready=1.
- MAX_CARDS=5, MOD=16, FACE_MIN=14 -> 13,13,13 gives 13,10,7; reset during 2nd card -> all reset values next cycle.
